iob_cache_be_mem: RTL and testbench

IOB_CACHE_BE_MEM -- requirements
Module: iob_cache_be_mem

---
 rtl/iob_cache_be_mem_pkg.sv | 14 +
 rtl/iob_cache_be_mem_lfsr.sv | 32 +++
 rtl/iob_cache_be_mem.sv | 117 +++++++++++
 tb/tb_iob_cache_be_mem.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_mem_pkg.sv
// Shared constants for the iob_cache_be_mem backing memory model.
// Holds the byte-offset width helper, LFSR tap mask and counter width.
package iob_cache_be_mem_pkg;

    localparam int CNT_W = 16;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int nb_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_cache_be_mem_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random ready stalls.
// Only instantiated when IOB_CACHE_BE_MEM_STALL_EN is defined.
module iob_cache_be_mem_lfsr
    import iob_cache_be_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        arst_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= SEED;
        end else if (cke_i && en_i) begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/iob_cache_be_mem.sv
// IOb subordinate memory model backing a cache, fixed read latency.
// Define IOB_CACHE_BE_MEM_STALL_EN for LFSR-driven ready backpressure.
module iob_cache_be_mem
    import iob_cache_be_mem_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter int          DATA_W     = 32,
    parameter int          MEM_ADDR_W = 10,
    parameter int          RD_LAT     = 2,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [CNT_W-1:0]    rd_cnt_o,
    output logic [CNT_W-1:0]    wr_cnt_o
);

    localparam int NB_W   = nb_w(DATA_W);
    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** MEM_ADDR_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [MEM_ADDR_W-1:0] idx;
    logic                  stall_ok;
    logic                  acc;
    logic                  acc_rd;
    logic                  acc_wr;

    logic [RD_LAT-1:0]     vld_q;
    logic [RD_LAT-1:0]     vld_d;
    logic [DATA_W-1:0]     dat_q [RD_LAT];
    logic [DATA_W-1:0]     dat_d [RD_LAT];
    logic [CNT_W-1:0]      rd_cnt_q;
    logic [CNT_W-1:0]      rd_cnt_d;
    logic [CNT_W-1:0]      wr_cnt_q;
    logic [CNT_W-1:0]      wr_cnt_d;

    logic                  unused_addr;

`ifdef IOB_CACHE_BE_MEM_STALL_EN
    logic [15:0] lfsr;
    logic        unused_lfsr;

    iob_cache_be_mem_lfsr #(
        .SEED(STALL_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .en_i   (1'b1),
        .state_o(lfsr)
    );

    assign stall_ok    = ~(lfsr[1:0] == 2'b00);
    assign unused_lfsr = ^lfsr[15:2];
`else
    assign stall_ok = 1'b1;
`endif

    assign unused_addr = ^iob_addr_i;
    assign idx         = iob_addr_i[NB_W +: MEM_ADDR_W];
    assign iob_ready_o = cke_i & ~arst_i & stall_ok;
    assign acc         = iob_valid_i & iob_ready_o;
    assign acc_wr      = acc & (|iob_wstrb_i);
    assign acc_rd      = acc & ~(|iob_wstrb_i);

    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (iob_wstrb_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= iob_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        vld_d[0] = acc_rd;
        dat_d[0] = mem_q[idx];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (acc_rd && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
        if (acc_wr && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            vld_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (cke_i) begin
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // A frozen pipe must not present its head twice, so gate by cke
    assign iob_rvalid_o = vld_q[RD_LAT-1] & cke_i & ~arst_i;
    assign iob_rdata_o  = iob_rvalid_o ? dat_q[RD_LAT-1] : '0;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Directed self-checking bench for iob_cache_be_mem.
// Stall ratio check is active when IOB_CACHE_BE_MEM_STALL_EN is defined.
module tb_iob_cache_be_mem;

    logic        clk = 1'b0;
    logic        cke;
    logic        arst;
    logic        valid;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int vectors = 0;
    int miscompares = 0;

    iob_cache_be_mem #(
        .ADDR_W    (24),
        .DATA_W    (32),
        .MEM_ADDR_W(10),
        .RD_LAT    (2),
        .STALL_SEED(16'hACE1)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .arst_i      (arst),
        .iob_valid_i (valid),
        .iob_addr_i  (addr),
        .iob_wdata_i (wdata),
        .iob_wstrb_i (wstrb),
        .iob_rvalid_o(rvalid),
        .iob_rdata_o (rdata),
        .iob_ready_o (ready),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        arst  = 1'b1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic req(input logic [23:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        bit got = 0;
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = ready;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL req_timeout addr=%h got ready=0 need 1", a);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic wait_rv(output bit seen, output logic [31:0] d);
        seen = 0;
        d = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1;
                d = rdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rvalid, ready} !== 2'b00 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out got rv=%b rdy=%b rd=%h need 0 0 0",
                     rvalid, ready, rdata);
        end
        vectors++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_cnt got %h/%h need 0/0", rd_cnt, wr_cnt);
        end
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset got %b need 1", ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        req(24'h10, 32'hDEADBEEF, 4'hF);
        req(24'h10, 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_early got rvalid=%b need 0", rvalid);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lat_data got %b/%h need 1/deadbeef",
                     rvalid, rdata);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL lat_pulse got %b/%h need 0/0", rvalid, rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_strobe();
        bit          seen;
        logic [31:0] d;
        req(24'h20, 32'hFFFFFFFF, 4'hF);
        req(24'h20, 32'h11223344, 4'h3);
        req(24'h20, 32'h0, 4'h0);
        wait_rv(seen, d);
        vectors++;
        if (!seen || d !== 32'hFFFF3344) begin
            miscompares++;
            $display("FAIL strobe got %b/%h need 1/ffff3344", seen, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [4];
        int          when [4];
        int          n = 0;
        for (int i = 0; i < 4; i++) begin
            req(24'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
        end
        apply_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    req(24'(i * 4), 32'h0, 4'h0);
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (rvalid && n < 4) begin
                        got[n]  = rdata;
                        when[n] = c;
                        n++;
                    end
                end
            end
        join
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL b2b_count got %0d need 4", n);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (got[i] !== 32'hC0DE0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL b2b_data[%0d] got %h need %h",
                         i, got[i], 32'hC0DE0000 + 32'(i));
            end
        end
`ifndef IOB_CACHE_BE_MEM_STALL_EN
        vectors++;
        if (n == 4 && when[3] - when[0] !== 3) begin
            miscompares++;
            $display("FAIL b2b_consec got span %0d need 3",
                     when[3] - when[0]);
        end
`endif
        vectors++;
        if (rd_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL b2b_rdcnt got %0d need 4", rd_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_flush();
        int pulses = 0;
        apply_reset();
        req(24'h0, 32'h0, 4'h0);
        arst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b0 || rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_in_reset got rdy=%b rv=%b need 0 0",
                     ready, rvalid);
        end
        @(posedge clk);
        #1 arst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL flush_rvalid got %0d pulses need 0", pulses);
        end
        vectors++;
        if (rd_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL flush_rdcnt got %0d need 0", rd_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alias();
        bit          seen;
        logic [31:0] d;
        req(24'h1000, 32'hA5A5A5A5, 4'hF);
        req(24'h0, 32'h0, 4'h0);
        wait_rv(seen, d);
        vectors++;
        if (!seen || d !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL alias got %b/%h need 1/a5a5a5a5", seen, d);
        end
    endtask

    task automatic test_cke();
        int          lo = 0;
        int          hi = 0;
        logic [31:0] d = '0;
        req(24'h10, 32'h0, 4'h0);
        cke = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rvalid) lo++;
        end
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cke_ready got %b need 0", ready);
        end
        @(posedge clk);
        #1 cke = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rvalid) begin
                hi++;
                d = rdata;
            end
        end
        vectors++;
        if (lo !== 0 || hi !== 1 || d !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL cke_hold got %0d/%0d/%h need 0/1/deadbeef",
                     lo, hi, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] m [64];
        logic [31:0] q [$];
        logic [31:0] exp;
        logic [5:0]  w;
        int nrd = 0, nwr = 0, done = 0;
        int cyc = 0, lowc = 0, rvn = 0;
        bit acc;
        for (int i = 0; i < 64; i++) begin
            m[i] = $urandom;
            req(24'(i * 4), m[i], 4'hF);
        end
        apply_reset();
        w = '0;
        valid = 1'b0;
        while ((done < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (rvalid) begin
                rvn++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra got rvalid=1 need 0");
                end else begin
                    exp = q.pop_front();
                    if (rdata !== exp) begin
                        miscompares++;
                        $display("FAIL rand_data got %h need %h",
                                 rdata, exp);
                    end
                end
            end
            if (!ready) lowc++;
            acc = valid && ready;
            if (acc) begin
                if (wstrb != 0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) m[w][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                    nwr++;
                end else begin
                    q.push_back(m[w]);
                    nrd++;
                end
                done++;
            end
            @(posedge clk);
            #1;
            if (acc || !valid) begin
                if (done < 1000) begin
                    w     = 6'($urandom_range(0, 63));
                    addr  = {12'($urandom), 4'h0, w, 2'($urandom)};
                    wdata = $urandom;
                    wstrb = $urandom_range(0, 1) ?
                            4'($urandom_range(1, 15)) : 4'h0;
                    valid = 1'b1;
                end else begin
                    valid = 1'b0;
                    wstrb = 4'h0;
                end
            end
        end
        vectors++;
        if (cyc >= 20000) begin
            miscompares++;
            $display("FAIL rand_timeout got %0d done need 1000", done);
        end
        vectors++;
        if (rd_cnt !== 16'(nrd) || wr_cnt !== 16'(nwr)) begin
            miscompares++;
            $display("FAIL rand_cnt got %0d/%0d need %0d/%0d",
                     rd_cnt, wr_cnt, nrd, nwr);
        end
        vectors++;
        if (rvn !== nrd) begin
            miscompares++;
            $display("FAIL rand_rvn got %0d need %0d", rvn, nrd);
        end
`ifdef IOB_CACHE_BE_MEM_STALL_EN
        vectors++;
        if (lowc * 100 < cyc * 20 || lowc * 100 > cyc * 30) begin
            miscompares++;
            $display("FAIL rand_stall got %0d/%0d low need 20-30%%",
                     lowc, cyc);
        end
`endif
    endtask

    initial begin
        cke   = 1'b1;
        arst  = 1'b1;
        valid = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        test_reset();
        test_write_read();
        test_strobe();
        test_back_to_back();
        test_reset_flush();
        test_alias();
        test_cke();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
